// File: rtl/pc_control_sequencer_pkg.sv
// rtl/pc_control_sequencer_pkg.sv - opcodes, state encoding and control-word layout for the T-state sequencer
package pc_control_sequencer_pkg;

  localparam int OP_W = 4;
  localparam int TS_W = 3;

  localparam logic [OP_W-1:0] OP_LDA = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB = 4'h2;
  localparam logic [OP_W-1:0] OP_JMP = 4'h3;
  localparam logic [OP_W-1:0] OP_STA = 4'h4;
  localparam logic [OP_W-1:0] OP_JC  = 4'h5;
  localparam logic [OP_W-1:0] OP_OUT = 4'hE;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // T1..T6 encode as 1..6 so the debug tstate is the state value itself
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_T1     = 3'd1,
    S_T2     = 3'd2,
    S_T3     = 3'd3,
    S_T4     = 3'd4,
    S_T5     = 3'd5,
    S_T6     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  localparam int CW_PC_EN   = 0;
  localparam int CW_PC_OE   = 1;
  localparam int CW_PC_WE   = 2;
  localparam int CW_PC_LOAD = 3;
  localparam int CW_MAR_WE  = 4;
  localparam int CW_RAM_OE  = 5;
  localparam int CW_RAM_WE  = 6;
  localparam int CW_IR_WE   = 7;
  localparam int CW_IR_OE   = 8;
  localparam int CW_A_WE    = 9;
  localparam int CW_A_OE    = 10;
  localparam int CW_B_WE    = 11;
  localparam int CW_ALU_OE  = 12;
  localparam int CW_ALU_SUB = 13;
  localparam int CW_OUT_WE  = 14;
  localparam int CW_W       = 15;

endpackage

// File: rtl/pc_control_sequencer_if.sv
// rtl/pc_control_sequencer_if.sv - datapath strobe and IR/flag bundle between sequencer and datapath
interface pc_control_sequencer_if;
  import pc_control_sequencer_pkg::*;

  logic [OP_W-1:0] opcode;
  logic            carry;
  logic pc_en, pc_oe, pc_we, pc_load;
  logic mar_we, ram_oe, ram_we, ir_we, ir_oe;
  logic a_we, a_oe, b_we, alu_oe, alu_sub, out_we;

  modport master (
    input  opcode, carry,
    output pc_en, pc_oe, pc_we, pc_load, mar_we, ram_oe, ram_we, ir_we, ir_oe,
           a_we, a_oe, b_we, alu_oe, alu_sub, out_we
  );

  modport slave (
    output opcode, carry,
    input  pc_en, pc_oe, pc_we, pc_load, mar_we, ram_oe, ram_we, ir_we, ir_oe,
           a_we, a_oe, b_we, alu_oe, alu_sub, out_we
  );

endinterface

// File: rtl/pc_control_sequencer_decode.sv
// rtl/pc_control_sequencer_decode.sv - combinational (state, opcode, carry) to control word decode
module pc_control_sequencer_decode
  import pc_control_sequencer_pkg::*;
(
  input  state_t          state,
  input  logic [OP_W-1:0] opcode,
  input  logic            carry,
  input  logic            prog,
  input  logic            prog_load,
  output logic [CW_W-1:0] cw,
  output logic            last,
  output logic            halt_req
);

  always_comb begin
    cw       = '0;
    last     = 1'b0;
    halt_req = 1'b0;
    unique case (state)
      S_IDLE: cw[CW_PC_LOAD] = prog_load & prog;
      S_T1: begin
        cw[CW_PC_OE]  = 1'b1;
        cw[CW_MAR_WE] = 1'b1;
      end
      S_T2: cw[CW_PC_EN] = 1'b1;
      S_T3: begin
        cw[CW_RAM_OE] = 1'b1;
        cw[CW_IR_WE]  = 1'b1;
      end
      S_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OE]  = 1'b1;
            cw[CW_MAR_WE] = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OE] = 1'b1;
            cw[CW_PC_WE] = 1'b1;
            last         = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OE] = carry;
            cw[CW_PC_WE] = carry;
            last         = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_OUT_WE] = 1'b1;
            last          = 1'b1;
          end
          OP_HLT: begin
            last     = 1'b1;
            halt_req = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OE] = 1'b1;
            cw[CW_A_WE]   = 1'b1;
            last          = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OE]  = 1'b1;
            cw[CW_B_WE]    = 1'b1;
            cw[CW_ALU_SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            cw[CW_A_OE]   = 1'b1;
            cw[CW_RAM_WE] = 1'b1;
            last          = 1'b1;
          end
          default: last = 1'b1;
        endcase
      end
      S_T6: begin
        cw[CW_ALU_OE]  = (opcode == OP_ADD) || (opcode == OP_SUB);
        cw[CW_A_WE]    = (opcode == OP_ADD) || (opcode == OP_SUB);
        cw[CW_ALU_SUB] = (opcode == OP_SUB);
        last           = 1'b1;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/pc_control_sequencer.sv
// rtl/pc_control_sequencer.sv - T-state sequencer top; optional single-step build via CTRL_SINGLE_STEP_EN
module pc_control_sequencer
  import pc_control_sequencer_pkg::*;
(
  input  logic CLK,
  input  logic RESET,
  input  logic run,
  input  logic prog,
  input  logic prog_load,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  pc_control_sequencer_if.master bus,
  output logic            halted,
  output logic [TS_W-1:0] tstate
);

  state_t          state, state_nxt, end_nxt;
  logic [CW_W-1:0] cw, cw_g;
  logic            last, halt_req;
  logic            advance, fire;

`ifdef CTRL_SINGLE_STEP_EN
  logic step_q, fire_q;

  // One state per step rising edge; strobes live only in the cycle after it
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      step_q <= 1'b0;
      fire_q <= 1'b0;
    end else begin
      step_q <= step;
      fire_q <= step & ~step_q;
    end
  end

  assign advance = step & ~step_q;
  assign fire    = fire_q;
`else
  assign advance = 1'b1;
  assign fire    = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else if (advance) begin
      state <= state_nxt;
    end
  end

  pc_control_sequencer_decode u_decode (
    .state     (state),
    .opcode    (bus.opcode),
    .carry     (bus.carry),
    .prog      (prog),
    .prog_load (prog_load),
    .cw        (cw),
    .last      (last),
    .halt_req  (halt_req)
  );

  always_comb begin
    end_nxt   = (run && !prog) ? S_T1 : S_IDLE;
    state_nxt = state;
    unique case (state)
      S_IDLE:   state_nxt = (run && !prog) ? S_T1 : S_IDLE;
      S_T1:     state_nxt = S_T2;
      S_T2:     state_nxt = S_T3;
      S_T3:     state_nxt = S_T4;
      S_T4:     state_nxt = halt_req ? S_HALTED : (last ? end_nxt : S_T5);
      S_T5:     state_nxt = last ? end_nxt : S_T6;
      S_T6:     state_nxt = end_nxt;
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Programmer PC load is an IDLE-mode action, not a sequenced strobe, so it is never step-gated
  always_comb begin
    cw_g             = fire ? cw : '0;
    cw_g[CW_PC_LOAD] = cw[CW_PC_LOAD];
    halted           = (state == S_HALTED);
    tstate           = (state == S_HALTED) ? '0 : TS_W'(state);
  end

  assign bus.pc_en   = cw_g[CW_PC_EN];
  assign bus.pc_oe   = cw_g[CW_PC_OE];
  assign bus.pc_we   = cw_g[CW_PC_WE];
  assign bus.pc_load = cw_g[CW_PC_LOAD];
  assign bus.mar_we  = cw_g[CW_MAR_WE];
  assign bus.ram_oe  = cw_g[CW_RAM_OE];
  assign bus.ram_we  = cw_g[CW_RAM_WE];
  assign bus.ir_we   = cw_g[CW_IR_WE];
  assign bus.ir_oe   = cw_g[CW_IR_OE];
  assign bus.a_we    = cw_g[CW_A_WE];
  assign bus.a_oe    = cw_g[CW_A_OE];
  assign bus.b_we    = cw_g[CW_B_WE];
  assign bus.alu_oe  = cw_g[CW_ALU_OE];
  assign bus.alu_sub = cw_g[CW_ALU_SUB];
  assign bus.out_we  = cw_g[CW_OUT_WE];

endmodule

// File: tb/tb_pc_control_sequencer.sv
// tb/tb_pc_control_sequencer.sv - self-checking bench for pc_control_sequencer against an instruction-table model
module tb_pc_control_sequencer;

  localparam logic [14:0] M_PC_EN   = 15'h4000;
  localparam logic [14:0] M_PC_OE   = 15'h2000;
  localparam logic [14:0] M_PC_WE   = 15'h1000;
  localparam logic [14:0] M_PC_LOAD = 15'h0800;
  localparam logic [14:0] M_MAR_WE  = 15'h0400;
  localparam logic [14:0] M_RAM_OE  = 15'h0200;
  localparam logic [14:0] M_RAM_WE  = 15'h0100;
  localparam logic [14:0] M_IR_WE   = 15'h0080;
  localparam logic [14:0] M_IR_OE   = 15'h0040;
  localparam logic [14:0] M_A_WE    = 15'h0020;
  localparam logic [14:0] M_A_OE    = 15'h0010;
  localparam logic [14:0] M_B_WE    = 15'h0008;
  localparam logic [14:0] M_ALU_OE  = 15'h0004;
  localparam logic [14:0] M_ALU_SUB = 15'h0002;
  localparam logic [14:0] M_OUT_WE  = 15'h0001;

  logic       CLK = 1'b0;
  logic       RESET, run, prog, prog_load;
  logic       halted;
  logic [2:0] tstate;
  int         tests = 0;
  int         fails = 0;
`ifdef CTRL_SINGLE_STEP_EN
  logic       step;
`endif

  pc_control_sequencer_if bus ();

  pc_control_sequencer dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .run       (run),
    .prog      (prog),
    .prog_load (prog_load),
`ifdef CTRL_SINGLE_STEP_EN
    .step      (step),
`endif
    .bus       (bus.master),
    .halted    (halted),
    .tstate    (tstate)
  );

  always #5 CLK = ~CLK;

  function automatic logic [14:0] obs_mask();
    return {bus.pc_en, bus.pc_oe, bus.pc_we, bus.pc_load, bus.mar_we, bus.ram_oe,
            bus.ram_we, bus.ir_we, bus.ir_oe, bus.a_we, bus.a_oe, bus.b_we,
            bus.alu_oe, bus.alu_sub, bus.out_we};
  endfunction

  // Instruction table: number of T-states per opcode
  function automatic int ins_len(input logic [3:0] op);
    case (op)
      4'h0, 4'h4: return 5;
      4'h1, 4'h2: return 6;
      default:    return 4;
    endcase
  endfunction

  // Instruction table: strobes expected in T-state t
  function automatic logic [14:0] exp_mask(input logic [3:0] op, input logic c, input int t);
    logic [14:0] sub;
    sub = (op == 4'h2) ? M_ALU_SUB : 15'h0;
    if (t == 1) return M_PC_OE | M_MAR_WE;
    if (t == 2) return M_PC_EN;
    if (t == 3) return M_RAM_OE | M_IR_WE;
    case (op)
      4'h0: return (t == 4) ? (M_IR_OE | M_MAR_WE) : (M_RAM_OE | M_A_WE);
      4'h1, 4'h2: begin
        if (t == 4) return M_IR_OE | M_MAR_WE;
        if (t == 5) return M_RAM_OE | M_B_WE | sub;
        return M_ALU_OE | M_A_WE | sub;
      end
      4'h3: return M_IR_OE | M_PC_WE;
      4'h4: return (t == 4) ? (M_IR_OE | M_MAR_WE) : (M_A_OE | M_RAM_WE);
      4'h5: return c ? (M_IR_OE | M_PC_WE) : 15'h0;
      4'hE: return M_A_OE | M_OUT_WE;
      default: return 15'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      chk("bus_onehot", 32'($countones({bus.pc_oe, bus.ram_oe, bus.ir_oe, bus.a_oe, bus.alu_oe}) <= 1), 32'd1);
      chk("pc_en_pc_we_excl", 32'(bus.pc_en & bus.pc_we), 32'd0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered just after the edge that moved the sequencer into T1
  task automatic run_instr(input logic [3:0] op, input logic c, input int drop_t);
    int pe;
    pe = 0;
    bus.opcode = op;
    bus.carry  = c;
    for (int t = 1; t <= ins_len(op); t++) begin
      @(negedge CLK);
      chk($sformatf("tstate op%0h", op), 32'(tstate), t);
      chk($sformatf("strobes op%0h T%0d", op, t), 32'(obs_mask()), 32'(exp_mask(op, c, t)));
      chk("halted_low", 32'(halted), 32'd0);
      if (bus.pc_en) pe++;
      if (t == drop_t) run = 1'b0;
      tick();
    end
    chk($sformatf("pc_en_count op%0h", op), pe, 1);
  endtask

  initial begin
    RESET = 1'b0; run = 1'b1; prog = 1'b0; prog_load = 1'b0;
    bus.opcode = 4'h0; bus.carry = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
    step = 1'b0;
`endif
    tick();
    tick();
    @(negedge CLK);
    chk("reset_strobes", 32'(obs_mask()), 32'd0);
    chk("reset_tstate", 32'(tstate), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    RESET = 1'b1;
    tick();
`ifdef CTRL_SINGLE_STEP_EN
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("step_hold_idle", 32'(tstate), 32'd0);
      tick();
    end
    step = 1'b1;
    for (int s = 1; s <= 2; s++) begin
      int strobe_cycles;
      strobe_cycles = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        @(negedge CLK);
        chk("step_tstate", 32'(tstate), s);
        if (obs_mask() != 15'h0) begin
          strobe_cycles++;
          chk("step_strobes", 32'(obs_mask()), 32'(exp_mask(4'h0, 1'b0, s)));
        end
      end
      chk("step_strobe_cycles", strobe_cycles, 1);
      step = 1'b0;
      tick();
      step = 1'b1;
    end
`else
    run_instr(4'h0, 1'b0, 0);
    run_instr(4'h1, 1'b0, 0);
    run_instr(4'h2, 1'b1, 0);
    run_instr(4'h3, 1'b0, 0);
    run_instr(4'h5, 1'b0, 0);
    run_instr(4'h5, 1'b1, 0);
    run_instr(4'h4, 1'b0, 0);
    run_instr(4'hE, 1'b1, 0);
    run_instr(4'h9, 1'b0, 0);
    for (int i = 0; i < 30; i++) begin
      logic [3:0] rop;
      logic       rc;
      rop = 4'($urandom_range(0, 14));
      rc  = 1'($urandom_range(0, 1));
      run_instr(rop, rc, 0);
    end
    // Dropping run mid-ADD must still let the instruction finish
    run_instr(4'h1, 1'b0, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("idle_after_drop", 32'(tstate), 32'd0);
      chk("idle_strobes", 32'(obs_mask()), 32'd0);
      tick();
    end
    prog = 1'b1; prog_load = 1'b1; run = 1'b1;
    @(negedge CLK);
    chk("prog_pc_load", 32'(obs_mask()), 32'(M_PC_LOAD));
    tick();
    @(negedge CLK);
    chk("prog_stays_idle", 32'(tstate), 32'd0);
    prog_load = 1'b0;
    @(negedge CLK);
    chk("prog_load_off", 32'(obs_mask()), 32'd0);
    prog = 1'b0;
    tick();
    run_instr(4'hF, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("halted_flag", 32'(halted), 32'd1);
      chk("halted_tstate", 32'(tstate), 32'd0);
      chk("halted_strobes", 32'(obs_mask()), 32'd0);
      if (i == 10) run = 1'b0;
      tick();
    end
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
